// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: one bit per cycle shift-add
// multiply and restoring divide, with optional single-cycle completion of trivial cases.
module muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter int FAST_PATH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] source,
  input  logic [WIDTH-1:0] arg_1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;        // {hi, lo} product, or {remainder, quotient}
  logic [WIDTH-1:0]     mag_q;      // multiplicand or divisor magnitude
  logic [2:0]           op_q;
  logic                 neg_q;
  logic                 special_q;

  // Operand decode for the request presented on the inputs
  logic                 src_neg, arg_neg, neg_in, special;
  logic [WIDTH-1:0]     src_mag, arg_mag, special_val;

  always_comb begin
    src_neg = source[WIDTH-1] &
              ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM));
    arg_neg = arg_1[WIDTH-1] & ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
    src_mag = src_neg ? -source : source;
    arg_mag = arg_neg ? -arg_1 : arg_1;
    // Remainder takes the dividend's sign; products and quotients the sign difference
    neg_in  = (op == OP_REM) ? src_neg : (src_neg ^ arg_neg);

    special     = 1'b0;
    special_val = '0;
    if (!op[2]) begin
      special = (source == '0) || (arg_1 == '0);
    end else if (arg_1 == '0) begin
      special     = 1'b1;
      special_val = op[1] ? source : '1;
    end else if (!op[0] && (source == MOST_NEG) && (arg_1 == '1)) begin
      special     = 1'b1;
      special_val = op[1] ? '0 : MOST_NEG;
    end
  end

  // One iteration of each algorithm, evaluated on the current accumulator
  logic [WIDTH:0]       mul_sum, div_shift;
  logic [WIDTH+1:0]     div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_q & {WIDTH{acc[0]}}};
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = {1'b0, div_shift} - {2'b00, mag_q};
    if (div_diff[WIDTH+1]) begin
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Sign fix-up and result selection used in FINISH
  logic [2*WIDTH-1:0]   prod_fin;
  logic [WIDTH-1:0]     div_pick, div_fin, fin_val;

  always_comb begin
    prod_fin = neg_q ? -acc : acc;
    div_pick = op_q[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
    div_fin  = neg_q ? -div_pick : div_pick;
    if (special_q) begin
      fin_val = acc[WIDTH-1:0];
    end else if (op_q[2]) begin
      fin_val = div_fin;
    end else if (op_q == OP_MUL) begin
      fin_val = prod_fin[WIDTH-1:0];
    end else begin
      fin_val = prod_fin[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ((FAST_PATH != 0) && special) ? FINISH : CALC;
      CALC:    if (cnt == CNT_W'(WIDTH-1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      acc       <= '0;
      mag_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            neg_q     <= neg_in;
            special_q <= special;
            cnt       <= '0;
            mag_q     <= op[2] ? arg_mag : src_mag;
            acc       <= {{WIDTH{1'b0}}, special ? special_val : (op[2] ? src_mag : arg_mag)};
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          // A precomputed special result just waits out the iterations
          if (!special_q) acc <= op_q[2] ? div_next : mul_next;
        end
        FINISH: begin
          result <= fin_val;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: 32-bit fast, 32-bit iterative-only and
// 8-bit instances, directed cases plus random operations against an arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  start_v = '0;
  logic [2:0]  op_v  [3];
  logic [31:0] src_v [3];
  logic [31:0] arg_v [3];
  wire  [2:0]  busy_v, done_v;
  wire  [31:0] res0, res1;
  wire  [7:0]  res8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .FAST_PATH(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .op(op_v[0]),
    .source(src_v[0]), .arg_1(arg_v[0]), .busy(busy_v[0]), .done(done_v[0]), .result(res0));

  muldiv_unit #(.WIDTH(32), .FAST_PATH(0)) dut_slow (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .op(op_v[1]),
    .source(src_v[1]), .arg_1(arg_v[1]), .busy(busy_v[1]), .done(done_v[1]), .result(res1));

  muldiv_unit #(.WIDTH(8), .FAST_PATH(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .op(op_v[2]),
    .source(src_v[2][7:0]), .arg_1(arg_v[2][7:0]), .busy(busy_v[2]), .done(done_v[2]),
    .result(res8));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] res_of(input int inst);
    case (inst)
      0:       return res0;
      1:       return res1;
      default: return {24'd0, res8};
    endcase
  endfunction

  function automatic int width_of(input int inst);
    return (inst == 2) ? 8 : 32;
  endfunction

  function automatic longint mask_of(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  // Reference: plain signed/unsigned arithmetic on 64-bit integers
  function automatic logic [31:0] ref_op(input int w, input logic [2:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, r, mask;
    bit     ovf;
    mask = mask_of(w);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = ua[w-1] ? ua - (longint'(1) << w) : ua;
    sb   = ub[w-1] ? ub - (longint'(1) << w) : ub;
    ovf  = (sa == -(longint'(1) << (w-1))) && (sb == -1);
    case (op)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >> w;
      3'd2: r = (sa * ub) >> w;
      3'd3: r = (ua * ub) >> w;
      3'd4: r = (ub == 0) ? -1 : (ovf ? sa : sa / sb);
      3'd5: r = (ub == 0) ? -1 : ua / ub;
      3'd6: r = (ub == 0) ? sa : (ovf ? 0 : sa % sb);
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return 32'(r & mask);
  endfunction

  // Cases that complete without iterating when the fast path is built in
  function automatic bit is_special(input int w, input logic [2:0] op,
                                    input logic [31:0] a, input logic [31:0] b);
    longint ua, ub;
    ua = longint'(a) & mask_of(w);
    ub = longint'(b) & mask_of(w);
    if (op < 3'd4) return (ua == 0) || (ub == 0);
    if (ub == 0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && (ua == (longint'(1) << (w-1))) && (ub == mask_of(w));
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'd1 << (w-1);
      3:       v = 32'($urandom_range(1, 9));
      4:       v = 32'd1;
      default: v = $urandom;
    endcase
    return v & 32'(mask_of(w));
  endfunction

  // Called just after an edge while the instance is idle or showing done
  task automatic launch(input int inst, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    op_v[inst]    = op;
    src_v[inst]   = a;
    arg_v[inst]   = b;
    start_v[inst] = 1'b1;
    @(posedge clk);
    #1;
    start_v[inst] = 1'b0;
    op_v[inst]    = 3'($urandom);
    src_v[inst]   = $urandom;
    arg_v[inst]   = $urandom;
    check($sformatf("i%0d busy_on_accept", inst), 64'(busy_v[inst]), 64'd1);
  endtask

  task automatic finish_op(input int inst, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input bit pulse);
    int    w, lat_exp, n;
    bit    busy_drop;
    string tag;
    w         = width_of(inst);
    lat_exp   = ((inst != 1) && is_special(w, op, a, b)) ? 1 : w + 1;
    tag       = $sformatf("i%0d op%0d a=%0h b=%0h", inst, op, a, b);
    n         = 0;
    busy_drop = 1'b0;
    while (!done_v[inst] && n < lat_exp + 10) begin
      if (!busy_v[inst]) busy_drop = 1'b1;
      start_v[inst] = pulse && (n == 3) && (lat_exp > 8);
      if (start_v[inst]) begin
        op_v[inst]  = 3'($urandom);
        src_v[inst] = $urandom;
        arg_v[inst] = $urandom;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start_v[inst] = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(lat_exp));
    check({tag, " result"}, 64'(res_of(inst)), 64'(exp));
    check({tag, " busy_in_done"}, 64'(busy_v[inst]), 64'd0);
    check({tag, " busy_held"}, 64'(busy_drop), 64'd0);
  endtask

  task automatic run_op(input int inst, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit pulse);
    launch(inst, op, a, b);
    finish_op(inst, op, a, b, exp, pulse);
  endtask

  task automatic run_rand(input int inst);
    logic [2:0]  op;
    logic [31:0] a, b;
    op = 3'($urandom_range(0, 7));
    a  = pick(width_of(inst));
    b  = pick(width_of(inst));
    run_op(inst, op, a, b, ref_op(width_of(inst), op, a, b), 1'($urandom_range(0, 1)));
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int done_seen;
    for (int i = 0; i < 3; i++) begin
      op_v[i]  = '0;
      src_v[i] = '0;
      arg_v[i] = '0;
    end
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("i%0d reset busy", i), 64'(busy_v[i]), 64'd0);
      check($sformatf("i%0d reset done", i), 64'(done_v[i]), 64'd0);
      check($sformatf("i%0d reset result", i), 64'(res_of(i)), 64'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases; each launch lands in the previous done cycle
    run_op(0, 3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    run_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    run_op(0, 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0);
    run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b1);
    run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
    run_op(0, 3'd5, 32'd100,       32'd7,         32'd14,        1'b1);
    run_op(0, 3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0);
    run_op(0, 3'd7, 32'd5,         32'd0,         32'd5,         1'b0);
    run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0);
    run_op(0, 3'd1, 32'd0,         32'h1234_5678, 32'd0,         1'b0);

    run_op(1, 3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b1);
    run_op(1, 3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0);
    run_op(1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);

    run_op(2, 3'd4, 32'h80,        32'hFF,        32'h80,        1'b0);
    run_op(2, 3'd0, 32'h0F,        32'h11,        32'hFF,        1'b0);
    run_op(2, 3'd6, 32'hF9,        32'h02,        32'hFF,        1'b1);

    // Reset in the middle of a divide
    launch(0, 3'd4, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid busy", 64'(busy_v[0]), 64'd0);
    check("rst_mid result", 64'(res0), 64'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_v[0]) done_seen++;
    end
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done_v[0]) done_seen++;
    end
    check("rst_mid no_done", 64'(done_seen), 64'd0);
    @(posedge clk);
    #1;
    run_op(0, 3'd0, 32'd3, 32'd4, 32'd12, 1'b0);

    for (int k = 0; k < 30; k++) run_rand(0);
    for (int k = 0; k < 12; k++) run_rand(1);
    for (int k = 0; k < 40; k++) run_rand(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
